rob_commit: RTL and testbench



---
 rtl/rob_commit_pkg.sv | 23 ++
 rtl/rob_retire_select.sv | 19 +
 rtl/rob_commit.sv | 158 +++++++++++++++
 tb/tb_rob_commit.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// Shared types and constants for the reorder-buffer commit stage.
// Entry layout, sizing constants and the circular pointer helper.
package rob_commit_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX   = 4;
    localparam int AR_SIZE   = 6;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic               valid;
        logic               done;
        logic [AR_SIZE-1:0] rd;
        logic [DATA_W-1:0]  data;
    } rob_entry_t;

    // Pointers are exactly ROB_IDX bits wide, so plain addition wraps modulo ROB_DEPTH.
    function automatic logic [ROB_IDX-1:0] ptr_inc(input logic [ROB_IDX-1:0] ptr,
                                                   input logic [ROB_IDX-1:0] amt);
        return ptr + amt;
    endfunction

endpackage

// File: rtl/rob_retire_select.sv
// Picks up to two oldest done entries for retirement; purely combinational.
// Zero latency; the younger slot only retires alongside the older one.
module rob_retire_select (
    input  logic       head_vld_i,
    input  logic       head_done_i,
    input  logic       next_vld_i,
    input  logic       next_done_i,
    output logic       r0_o,
    output logic       r1_o,
    output logic [1:0] retire_count_o
);

    always_comb begin
        r0_o           = head_vld_i && head_done_i;
        r1_o           = r0_o && next_vld_i && next_done_i;
        retire_count_o = {1'b0, r0_o} + {1'b0, r1_o};
    end

endmodule

// File: rtl/rob_commit.sv
// 2-wide in-order commit: circular ROB, out-of-order completion, registered ARF writes.
// Writeback at edge E retires at edge E+1; alloc_ready drops while all entries are held.
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               alloc_valid,
    input  logic [AR_SIZE-1:0] alloc_rd,
    output logic               alloc_ready,
    output logic [ROB_IDX-1:0] alloc_idx,
    input  logic               wb_valid1,
    input  logic               wb_valid2,
    input  logic [ROB_IDX-1:0] wb_idx1,
    input  logic [ROB_IDX-1:0] wb_idx2,
    input  logic [DATA_W-1:0]  wb_data1,
    input  logic [DATA_W-1:0]  wb_data2,
    input  logic               flush,
    output logic [AR_SIZE-1:0] write_addr1,
    output logic [AR_SIZE-1:0] write_addr2,
    output logic [DATA_W-1:0]  write_data1,
    output logic [DATA_W-1:0]  write_data2,
    output logic               write_en,
    output logic [1:0]         retire_count,
    output logic               rob_empty
);

    localparam logic [ROB_IDX:0] FULL_CNT = (ROB_IDX+1)'(ROB_DEPTH);

    rob_entry_t         entries_q [ROB_DEPTH];
    rob_entry_t         entries_d [ROB_DEPTH];
    logic [ROB_IDX-1:0] head_q, head_d;
    logic [ROB_IDX-1:0] tail_q, tail_d;
    logic [ROB_IDX:0]   count_q, count_d;

    logic               wen_q, wen_d;
    logic [AR_SIZE-1:0] waddr1_q, waddr1_d;
    logic [AR_SIZE-1:0] waddr2_q, waddr2_d;
    logic [DATA_W-1:0]  wdata1_q, wdata1_d;
    logic [DATA_W-1:0]  wdata2_q, wdata2_d;
    logic [1:0]         rcnt_q, rcnt_d;

    logic [ROB_IDX-1:0] head_p1;
    logic               r0, r1;
    logic [1:0]         ret_cnt;
    logic               alloc_fire;

    assign head_p1     = ptr_inc(head_q, ROB_IDX'(1));
    assign alloc_ready = (count_q < FULL_CNT);
    assign alloc_idx   = tail_q;
    assign rob_empty   = (count_q == '0);
    assign alloc_fire  = alloc_valid && alloc_ready;

    rob_retire_select u_retire_select (
        .head_vld_i     (entries_q[head_q].valid),
        .head_done_i    (entries_q[head_q].done),
        .next_vld_i     (entries_q[head_p1].valid),
        .next_done_i    (entries_q[head_p1].done),
        .r0_o           (r0),
        .r1_o           (r1),
        .retire_count_o (ret_cnt)
    );

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wen_d     = 1'b0;
        waddr1_d  = '0;
        waddr2_d  = '0;
        wdata1_d  = '0;
        wdata2_d  = '0;
        rcnt_d    = 2'd0;

        if (flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_d[i] = '0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Port 2 is applied last so it wins when both ports hit the same entry.
            if (wb_valid1 && entries_q[wb_idx1].valid) begin
                entries_d[wb_idx1].done = 1'b1;
                entries_d[wb_idx1].data = wb_data1;
            end
            if (wb_valid2 && entries_q[wb_idx2].valid) begin
                entries_d[wb_idx2].done = 1'b1;
                entries_d[wb_idx2].data = wb_data2;
            end

            if (r0) begin
                wen_d             = 1'b1;
                waddr1_d          = entries_q[head_q].rd;
                wdata1_d          = entries_q[head_q].data;
                entries_d[head_q] = '0;
            end
            if (r1) begin
                waddr2_d           = entries_q[head_p1].rd;
                wdata2_d           = entries_q[head_p1].data;
                entries_d[head_p1] = '0;
            end
            rcnt_d = ret_cnt;
            head_d = ptr_inc(head_q, ROB_IDX'(ret_cnt));

            // The tail slot is always free when alloc_ready is high, so it never collides with retire.
            if (alloc_fire) begin
                entries_d[tail_q].valid = 1'b1;
                entries_d[tail_q].done  = 1'b0;
                entries_d[tail_q].rd    = alloc_rd;
                entries_d[tail_q].data  = '0;
                tail_d                  = ptr_inc(tail_q, ROB_IDX'(1));
            end

            count_d = count_q + (ROB_IDX+1)'(alloc_fire) - (ROB_IDX+1)'(ret_cnt);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wen_q    <= 1'b0;
            waddr1_q <= '0;
            waddr2_q <= '0;
            wdata1_q <= '0;
            wdata2_q <= '0;
            rcnt_q   <= 2'd0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            wen_q    <= wen_d;
            waddr1_q <= waddr1_d;
            waddr2_q <= waddr2_d;
            wdata1_q <= wdata1_d;
            wdata2_q <= wdata2_d;
            rcnt_q   <= rcnt_d;
        end
    end

    assign write_en     = wen_q;
    assign write_addr1  = waddr1_q;
    assign write_addr2  = waddr2_q;
    assign write_data1  = wdata1_q;
    assign write_data2  = wdata2_q;
    assign retire_count = rcnt_q;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: each scenario task drives vectors and checks hand-computed results.
module tb_rob_commit;

    logic        clk;
    logic        rstn;
    logic        alloc_valid;
    logic [5:0]  alloc_rd;
    logic        alloc_ready;
    logic [3:0]  alloc_idx;
    logic        wb_valid1, wb_valid2;
    logic [3:0]  wb_idx1, wb_idx2;
    logic [31:0] wb_data1, wb_data2;
    logic        flush;
    logic [5:0]  write_addr1, write_addr2;
    logic [31:0] write_data1, write_data2;
    logic        write_en;
    logic [1:0]  retire_count;
    logic        rob_empty;

    int tests_run    = 0;
    int tests_failed = 0;

    rob_commit dut (
        .clk          (clk),
        .rstn         (rstn),
        .alloc_valid  (alloc_valid),
        .alloc_rd     (alloc_rd),
        .alloc_ready  (alloc_ready),
        .alloc_idx    (alloc_idx),
        .wb_valid1    (wb_valid1),
        .wb_valid2    (wb_valid2),
        .wb_idx1      (wb_idx1),
        .wb_idx2      (wb_idx2),
        .wb_data1     (wb_data1),
        .wb_data2     (wb_data2),
        .flush        (flush),
        .write_addr1  (write_addr1),
        .write_addr2  (write_addr2),
        .write_data1  (write_data1),
        .write_data2  (write_data2),
        .write_en     (write_en),
        .retire_count (retire_count),
        .rob_empty    (rob_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0;
        alloc_rd    = '0;
        wb_valid1   = 1'b0;
        wb_valid2   = 1'b0;
        wb_idx1     = '0;
        wb_idx2     = '0;
        wb_data1    = '0;
        wb_data2    = '0;
        flush       = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        #7;
        tests_run++;
        if (write_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wen got %0h exp 0", write_en); end
        tests_run++;
        if (retire_count !== 2'd0) begin tests_failed++; $display("FAIL reset_rcnt got %0d exp 0", retire_count); end
        tests_run++;
        if (write_addr1 !== 6'd0 || write_addr2 !== 6'd0 || write_data1 !== 32'd0 || write_data2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_wport got %0h/%0h/%0h/%0h exp 0/0/0/0", write_addr1, write_addr2, write_data1, write_data2);
        end
        tests_run++;
        if (rob_empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_status got empty=%0b rdy=%0b idx=%0d exp 1/1/0", rob_empty, alloc_ready, alloc_idx);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        alloc_valid = 1'b1; alloc_rd = 6'd5;
        tests_run++;
        if (alloc_idx !== 4'd0) begin tests_failed++; $display("FAIL io_idx0 got %0d exp 0", alloc_idx); end
        tick();
        alloc_rd = 6'd7;
        tests_run++;
        if (alloc_idx !== 4'd1) begin tests_failed++; $display("FAIL io_idx1 got %0d exp 1", alloc_idx); end
        tick();
        alloc_valid = 1'b0;
        wb_valid1 = 1'b1; wb_idx1 = 4'd1; wb_data1 = 32'hBEEF;
        tick();
        wb_valid1 = 1'b0;
        tick();
        tests_run++;
        if (write_en !== 1'b0) begin tests_failed++; $display("FAIL io_wait1 got wen=%0b exp 0", write_en); end
        wb_valid1 = 1'b1; wb_idx1 = 4'd0; wb_data1 = 32'h1234;
        tick();
        wb_valid1 = 1'b0;
        tests_run++;
        if (write_en !== 1'b0) begin tests_failed++; $display("FAIL io_wait2 got wen=%0b exp 0", write_en); end
        tick();
        tests_run++;
        if (write_en !== 1'b1 || retire_count !== 2'd2) begin
            tests_failed++;
            $display("FAIL io_retire got wen=%0b rc=%0d exp 1/2", write_en, retire_count);
        end
        tests_run++;
        if (write_addr1 !== 6'd5 || write_data1 !== 32'h1234 || write_addr2 !== 6'd7 || write_data2 !== 32'hBEEF) begin
            tests_failed++;
            $display("FAIL io_data got %0d/%0h %0d/%0h exp 5/1234 7/beef", write_addr1, write_data1, write_addr2, write_data2);
        end
        tick();
        tests_run++;
        if (write_en !== 1'b0 || rob_empty !== 1'b1 || alloc_idx !== 4'd2) begin
            tests_failed++;
            $display("FAIL io_after got wen=%0b empty=%0b idx=%0d exp 0/1/2", write_en, rob_empty, alloc_idx);
        end
    endtask

    task automatic test_single();
        alloc_valid = 1'b1; alloc_rd = 6'd3;
        tick();
        alloc_valid = 1'b0;
        wb_valid1 = 1'b1; wb_idx1 = 4'd2; wb_data1 = 32'hA5;
        tick();
        wb_valid1 = 1'b0;
        tick();
        tests_run++;
        if (write_en !== 1'b1 || retire_count !== 2'd1 || write_addr1 !== 6'd3 || write_data1 !== 32'hA5) begin
            tests_failed++;
            $display("FAIL single_slot1 got wen=%0b rc=%0d %0d/%0h exp 1/1 3/a5", write_en, retire_count, write_addr1, write_data1);
        end
        tests_run++;
        if (write_addr2 !== 6'd0 || write_data2 !== 32'd0) begin
            tests_failed++;
            $display("FAIL single_slot2 got %0d/%0h exp 0/0", write_addr2, write_data2);
        end
    endtask

    task automatic test_full();
        do_flush();
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1; alloc_rd = 6'(i + 1);
            tick();
        end
        alloc_valid = 1'b0;
        tests_run++;
        if (alloc_ready !== 1'b0 || alloc_idx !== 4'd0 || rob_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_state got rdy=%0b idx=%0d empty=%0b exp 0/0/0", alloc_ready, alloc_idx, rob_empty);
        end
        wb_valid1 = 1'b1; wb_idx1 = 4'd0; wb_data1 = 32'h100;
        alloc_valid = 1'b1; alloc_rd = 6'd20;
        tick();
        wb_valid1 = 1'b0;
        tests_run++;
        if (alloc_ready !== 1'b0) begin tests_failed++; $display("FAIL full_done_rdy got %0b exp 0", alloc_ready); end
        tick();
        tests_run++;
        if (write_en !== 1'b1 || retire_count !== 2'd1 || write_addr1 !== 6'd1 || write_data1 !== 32'h100) begin
            tests_failed++;
            $display("FAIL full_retire got wen=%0b rc=%0d %0d/%0h exp 1/1 1/100", write_en, retire_count, write_addr1, write_data1);
        end
        tests_run++;
        if (alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL full_blocked got rdy=%0b idx=%0d exp 1/0", alloc_ready, alloc_idx);
        end
        tick();
        alloc_valid = 1'b0;
        tests_run++;
        if (alloc_ready !== 1'b0 || alloc_idx !== 4'd1 || write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_refill got rdy=%0b idx=%0d wen=%0b exp 0/1/0", alloc_ready, alloc_idx, write_en);
        end
    endtask

    task automatic test_wrap();
        do_flush();
        for (int i = 0; i < 15; i++) begin
            alloc_valid = 1'b1; alloc_rd = 6'd1;
            tick();
        end
        alloc_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wb_valid1 = 1'b1; wb_idx1 = 4'(2 * k); wb_data1 = 32'(k);
            wb_valid2 = (2 * k + 1) < 15; wb_idx2 = 4'(2 * k + 1); wb_data2 = 32'(k);
            tick();
        end
        wb_valid1 = 1'b0; wb_valid2 = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        tests_run++;
        if (rob_empty !== 1'b1 || alloc_idx !== 4'd15) begin
            tests_failed++;
            $display("FAIL wrap_drain got empty=%0b idx=%0d exp 1/15", rob_empty, alloc_idx);
        end
        alloc_valid = 1'b1; alloc_rd = 6'd9;
        tick();
        alloc_rd = 6'd10;
        tests_run++;
        if (alloc_idx !== 4'd0) begin tests_failed++; $display("FAIL wrap_idx got %0d exp 0", alloc_idx); end
        tick();
        alloc_valid = 1'b0;
        wb_valid1 = 1'b1; wb_idx1 = 4'd15; wb_data1 = 32'h9999;
        wb_valid2 = 1'b1; wb_idx2 = 4'd0;  wb_data2 = 32'hAAAA;
        tick();
        wb_valid1 = 1'b0; wb_valid2 = 1'b0;
        tick();
        tests_run++;
        if (write_en !== 1'b1 || retire_count !== 2'd2 || write_addr1 !== 6'd9 || write_data1 !== 32'h9999 ||
            write_addr2 !== 6'd10 || write_data2 !== 32'hAAAA) begin
            tests_failed++;
            $display("FAIL wrap_pair got wen=%0b rc=%0d %0d/%0h %0d/%0h exp 1/2 9/9999 10/aaaa",
                     write_en, retire_count, write_addr1, write_data1, write_addr2, write_data2);
        end
        tests_run++;
        if (rob_empty !== 1'b1 || alloc_idx !== 4'd1) begin
            tests_failed++;
            $display("FAIL wrap_head got empty=%0b idx=%0d exp 1/1", rob_empty, alloc_idx);
        end
    endtask

    task automatic test_wb_conflict();
        alloc_valid = 1'b1; alloc_rd = 6'd4;
        tick();
        alloc_valid = 1'b0;
        wb_valid1 = 1'b1; wb_idx1 = 4'd1; wb_data1 = 32'h1111;
        wb_valid2 = 1'b1; wb_idx2 = 4'd1; wb_data2 = 32'h2222;
        tick();
        wb_valid1 = 1'b0; wb_valid2 = 1'b0;
        tick();
        tests_run++;
        if (write_en !== 1'b1 || retire_count !== 2'd1 || write_addr1 !== 6'd4 || write_data1 !== 32'h2222) begin
            tests_failed++;
            $display("FAIL conflict got wen=%0b rc=%0d %0d/%0h exp 1/1 4/2222", write_en, retire_count, write_addr1, write_data1);
        end
    endtask

    task automatic test_flush();
        alloc_valid = 1'b1; alloc_rd = 6'd6;
        tick();
        alloc_valid = 1'b0;
        wb_valid1 = 1'b1; wb_idx1 = 4'd2; wb_data1 = 32'h77;
        tick();
        flush = 1'b1;
        alloc_valid = 1'b1; alloc_rd = 6'd8;
        wb_valid1 = 1'b1; wb_idx1 = 4'd2; wb_data1 = 32'h55;
        tick();
        idle_inputs();
        tests_run++;
        if (write_en !== 1'b0 || retire_count !== 2'd0 || write_addr1 !== 6'd0) begin
            tests_failed++;
            $display("FAIL flush_outputs got wen=%0b rc=%0d addr=%0d exp 0/0/0", write_en, retire_count, write_addr1);
        end
        tests_run++;
        if (rob_empty !== 1'b1 || alloc_idx !== 4'd0 || alloc_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_state got empty=%0b idx=%0d rdy=%0b exp 1/0/1", rob_empty, alloc_idx, alloc_ready);
        end
        wb_valid1 = 1'b1; wb_idx1 = 4'd0; wb_data1 = 32'h99;
        wb_valid2 = 1'b1; wb_idx2 = 4'd2; wb_data2 = 32'h98;
        tick();
        idle_inputs();
        tick();
        tests_run++;
        if (write_en !== 1'b0 || rob_empty !== 1'b1 || alloc_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL flush_stale_wb got wen=%0b empty=%0b idx=%0d exp 0/1/0", write_en, rob_empty, alloc_idx);
        end
    endtask

    task automatic test_reset_mid();
        alloc_valid = 1'b1; alloc_rd = 6'd12;
        tick();
        alloc_rd = 6'd13;
        wb_valid1 = 1'b1; wb_idx1 = 4'd0; wb_data1 = 32'hCAFE;
        tick();
        idle_inputs();
        tick();
        tests_run++;
        if (write_en !== 1'b1 || write_addr1 !== 6'd12 || rob_empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_pre got wen=%0b addr=%0d empty=%0b exp 1/12/0", write_en, write_addr1, rob_empty);
        end
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if (write_en !== 1'b0 || retire_count !== 2'd0 || write_addr1 !== 6'd0 || write_data1 !== 32'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_out got wen=%0b rc=%0d %0d/%0h exp 0/0 0/0", write_en, retire_count, write_addr1, write_data1);
        end
        tests_run++;
        if (rob_empty !== 1'b1 || alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
            tests_failed++;
            $display("FAIL mid_reset_state got empty=%0b rdy=%0b idx=%0d exp 1/1/0", rob_empty, alloc_ready, alloc_idx);
        end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_single();
        test_full();
        test_wrap();
        test_wb_conflict();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
